// File: rtl/aecho_pkg.sv
// Shared types and default widths for the aecho datapath.
package aecho_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int DELAY_WIDTH_DEF   = 8;
  localparam int HEARD_COUNT_WIDTH = 32;

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter; done flags the last counting cycle (value==1).
module delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/echo_responder.sv
// Drains one word from the echo request FIFO, holds it for a programmable
// delay, then delivers it through the heard indication and counts deliveries.
//
// state | meaning
// IDLE  | waiting for a FIFO head word; delay register writable
// HOLD  | word captured, counting down the programmed delay
// SEND  | presenting the word on ind_heard_v until the sink accepts
module echo_responder
  import aecho_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DELAY_WIDTH = DELAY_WIDTH_DEF,
  parameter int COUNT_WIDTH = HEARD_COUNT_WIDTH
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   fifo_first__RDY,
  input  logic [DATA_WIDTH-1:0]  fifo_first,
  input  logic                   fifo_deq__RDY,
  output logic                   fifo_deq__ENA,
  input  logic                   ind_heard__RDY,
  output logic                   ind_heard__ENA,
  output logic [DATA_WIDTH-1:0]  ind_heard_v,
  output logic                   setDelay__RDY,
  input  logic                   setDelay__ENA,
  input  logic [DELAY_WIDTH-1:0] setDelay_v,
  output logic [COUNT_WIDTH-1:0] heard_count
);

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  held_q, held_d;
  logic [DELAY_WIDTH-1:0] delay_cfg_q, delay_cfg_d;
  logic [COUNT_WIDTH-1:0] heard_count_q, heard_count_d;
  logic                   cnt_load;
  logic                   cnt_done;

  // nRST gating keeps the dequeue strobe quiet while reset is held.
  assign fifo_deq__ENA  = nRST && (state_q == IDLE) && fifo_first__RDY && fifo_deq__RDY;
  assign ind_heard__ENA = (state_q == SEND) && ind_heard__RDY;
  assign ind_heard_v    = (state_q == SEND) ? held_q : '0;
  assign setDelay__RDY  = (state_q == IDLE);
  assign heard_count    = heard_count_q;

  // Capture uses the delay already in place, even if a write lands this cycle.
  assign cnt_load = fifo_deq__ENA && (delay_cfg_q != '0);

  delay_counter #(
    .WIDTH(DELAY_WIDTH)
  ) u_delay_counter (
    .clk        (CLK),
    .rst_n      (nRST),
    .load_i     (cnt_load),
    .load_val_i (delay_cfg_q),
    .en_i       (state_q == HOLD),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d       = state_q;
    held_d        = held_q;
    delay_cfg_d   = delay_cfg_q;
    heard_count_d = heard_count_q;

    if (setDelay__ENA && setDelay__RDY) begin
      delay_cfg_d = setDelay_v;
    end

    unique case (state_q)
      IDLE: begin
        if (fifo_deq__ENA) begin
          held_d  = fifo_first;
          state_d = (delay_cfg_q == '0) ? SEND : HOLD;
        end
      end
      HOLD: begin
        if (cnt_done) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ind_heard__ENA) begin
          heard_count_d = heard_count_q + COUNT_WIDTH'(1);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      held_q        <= '0;
      delay_cfg_q   <= '0;
      heard_count_q <= '0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      delay_cfg_q   <= delay_cfg_d;
      heard_count_q <= heard_count_d;
    end
  end

endmodule

// File: tb/tb_echo_responder.sv
// Directed bench for echo_responder; a narrow-count twin shares the stimulus
// so the heard_count wrap can be reached in a handful of sends.
module tb_echo_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        fifo_first__RDY;
  logic [31:0] fifo_first;
  logic        fifo_deq__RDY;
  logic        fifo_deq__ENA, fifo_deq__ENA_w;
  logic        ind_heard__RDY;
  logic        ind_heard__ENA, ind_heard__ENA_w;
  logic [31:0] ind_heard_v, ind_heard_v_w;
  logic        setDelay__RDY, setDelay__RDY_w;
  logic        setDelay__ENA;
  logic [7:0]  setDelay_v;
  logic [31:0] heard_count;
  logic [2:0]  heard_count_w;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  echo_responder dut (
    .CLK(CLK), .nRST(nRST),
    .fifo_first__RDY(fifo_first__RDY), .fifo_first(fifo_first),
    .fifo_deq__RDY(fifo_deq__RDY), .fifo_deq__ENA(fifo_deq__ENA),
    .ind_heard__RDY(ind_heard__RDY), .ind_heard__ENA(ind_heard__ENA),
    .ind_heard_v(ind_heard_v),
    .setDelay__RDY(setDelay__RDY), .setDelay__ENA(setDelay__ENA),
    .setDelay_v(setDelay_v), .heard_count(heard_count)
  );

  echo_responder #(.COUNT_WIDTH(3)) dut_w (
    .CLK(CLK), .nRST(nRST),
    .fifo_first__RDY(fifo_first__RDY), .fifo_first(fifo_first),
    .fifo_deq__RDY(fifo_deq__RDY), .fifo_deq__ENA(fifo_deq__ENA_w),
    .ind_heard__RDY(ind_heard__RDY), .ind_heard__ENA(ind_heard__ENA_w),
    .ind_heard_v(ind_heard_v_w),
    .setDelay__RDY(setDelay__RDY_w), .setDelay__ENA(setDelay__ENA),
    .setDelay_v(setDelay_v), .heard_count(heard_count_w)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_delay(input logic [7:0] d);
    setDelay__ENA = 1'b1;
    setDelay_v    = d;
    cyc();
    setDelay__ENA = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    fifo_first__RDY = 1'b0;
    fifo_first = '0;
    fifo_deq__RDY = 1'b1;
    ind_heard__RDY = 1'b1;
    setDelay__ENA = 1'b0;
    setDelay_v = '0;

    // Reset state
    repeat (2) cyc();
    check_val("rst_deq", {31'b0, fifo_deq__ENA}, 32'd0);
    check_val("rst_heard", {31'b0, ind_heard__ENA}, 32'd0);
    check_val("rst_v", ind_heard_v, 32'd0);
    check_val("rst_count", heard_count, 32'd0);
    nRST = 1'b1;
    cyc();

    // 1: delay 0, single word
    fifo_first = 32'hDEADBEEF;
    fifo_first__RDY = 1'b1;
    #1;
    check_val("t1_deq", {31'b0, fifo_deq__ENA}, 32'd1);
    cyc();
    fifo_first__RDY = 1'b0;
    #1;
    check_val("t1_heard", {31'b0, ind_heard__ENA}, 32'd1);
    check_val("t1_v", ind_heard_v, 32'hDEADBEEF);
    check_val("t1_deq_off", {31'b0, fifo_deq__ENA}, 32'd0);
    cyc();
    check_val("t1_count", heard_count, 32'd1);
    check_val("t1_idle", {31'b0, setDelay__RDY}, 32'd1);

    // 2: delay 5
    set_delay(8'd5);
    fifo_first = 32'h12345678;
    fifo_first__RDY = 1'b1;
    #1;
    check_val("t2_deq", {31'b0, fifo_deq__ENA}, 32'd1);
    cyc();
    fifo_first__RDY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check_val("t2_hold_heard", {31'b0, ind_heard__ENA}, 32'd0);
      check_val("t2_hold_sdrdy", {31'b0, setDelay__RDY}, 32'd0);
      cyc();
    end
    check_val("t2_heard", {31'b0, ind_heard__ENA}, 32'd1);
    check_val("t2_v", ind_heard_v, 32'h12345678);
    check_val("t2_send_sdrdy", {31'b0, setDelay__RDY}, 32'd0);
    cyc();
    check_val("t2_count", heard_count, 32'd2);

    // 3: sink stalls 10 cycles in SEND, FIFO keeps offering
    ind_heard__RDY = 1'b0;
    fifo_first__RDY = 1'b1;
    #1;
    check_val("t3_deq", {31'b0, fifo_deq__ENA}, 32'd1);
    cyc();
    fifo_first = 32'hFFFF0000;
    repeat (5) cyc();
    for (int i = 0; i < 10; i++) begin
      check_val("t3_stall_v", ind_heard_v, 32'h12345678);
      check_val("t3_stall_deq", {31'b0, fifo_deq__ENA}, 32'd0);
      check_val("t3_stall_heard", {31'b0, ind_heard__ENA}, 32'd0);
      cyc();
    end
    fifo_first__RDY = 1'b0;
    ind_heard__RDY = 1'b1;
    #1;
    check_val("t3_fire", {31'b0, ind_heard__ENA}, 32'd1);
    cyc();
    check_val("t3_count", heard_count, 32'd3);
    check_val("t3_heard_off", {31'b0, ind_heard__ENA}, 32'd0);

    // 4: delay write coincides with capture; old delay 0 governs that word
    set_delay(8'd0);
    fifo_first = 32'h000000A1;
    fifo_first__RDY = 1'b1;
    setDelay__ENA = 1'b1;
    setDelay_v = 8'd3;
    #1;
    check_val("t4_deq", {31'b0, fifo_deq__ENA}, 32'd1);
    cyc();
    setDelay__ENA = 1'b0;
    fifo_first__RDY = 1'b0;
    #1;
    check_val("t4_fire1", {31'b0, ind_heard__ENA}, 32'd1);
    check_val("t4_v1", ind_heard_v, 32'h000000A1);
    cyc();
    fifo_first = 32'h000000B2;
    fifo_first__RDY = 1'b1;
    cyc();
    fifo_first__RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("t4_hold", {31'b0, ind_heard__ENA}, 32'd0);
      cyc();
    end
    check_val("t4_fire2", {31'b0, ind_heard__ENA}, 32'd1);
    check_val("t4_v2", ind_heard_v, 32'h000000B2);
    cyc();
    check_val("t4_count", heard_count, 32'd5);

    // 5: async reset mid-HOLD (delay is 3)
    fifo_first = 32'h000000C3;
    fifo_first__RDY = 1'b1;
    cyc();
    #2;
    nRST = 1'b0;
    #1;
    check_val("t5_rst_heard", {31'b0, ind_heard__ENA}, 32'd0);
    check_val("t5_rst_v", ind_heard_v, 32'd0);
    check_val("t5_rst_deq", {31'b0, fifo_deq__ENA}, 32'd0);
    check_val("t5_rst_count", heard_count, 32'd0);
    fifo_first__RDY = 1'b0;
    cyc();
    nRST = 1'b1;
    #1;
    check_val("t5_idle", {31'b0, setDelay__RDY}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_val("t5_no_emit", {31'b0, ind_heard__ENA}, 32'd0);
      cyc();
    end
    fifo_first = 32'h000000D4;
    fifo_first__RDY = 1'b1;
    cyc();
    fifo_first__RDY = 1'b0;
    #1;
    check_val("t5_delay0", {31'b0, ind_heard__ENA}, 32'd1);
    check_val("t5_v", ind_heard_v, 32'h000000D4);
    cyc();
    check_val("t5_count", heard_count, 32'd1);
    check_val("t5_count_w", {29'b0, heard_count_w}, 32'd1);

    // 6: back-to-back sends take the 3-bit twin through its wrap
    fifo_first__RDY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fifo_first = 32'h100 + i;
      #1;
      check_val("t6_deq", {31'b0, fifo_deq__ENA}, 32'd1);
      cyc();
      check_val("t6_no_deq_in_send", {31'b0, fifo_deq__ENA}, 32'd0);
      check_val("t6_heard", {31'b0, ind_heard__ENA}, 32'd1);
      if (i == 6) check_val("t6_pre_wrap_w", {29'b0, heard_count_w}, 32'd7);
      cyc();
    end
    fifo_first__RDY = 1'b0;
    check_val("t6_wrap_w", {29'b0, heard_count_w}, 32'd0);
    check_val("t6_count", heard_count, 32'd8);

    // Max delay: 255 HOLD cycles, fire 256 cycles after dequeue
    set_delay(8'd255);
    fifo_first = 32'h0000FFFF;
    fifo_first__RDY = 1'b1;
    cyc();
    fifo_first__RDY = 1'b0;
    begin
      int n;
      n = 1;
      while (!ind_heard__ENA && n < 400) begin
        cyc();
        n++;
      end
      check_val("max_delay_latency", n, 32'd256);
    end
    check_val("max_delay_v", ind_heard_v, 32'h0000FFFF);
    cyc();
    check_val("max_delay_count", heard_count, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
